phase_sequencer: RTL and testbench

- Synchronous four-phase instruction-cycle sequencer driven by the single system clock.
- Produces one-hot phase strobes in the order 1000, 0100, 0010, 0001 (fetch, decode, execute, writeback) for the datapath.
- Adds memory-wait stalls, halting at instruction boundaries, a retired-instruction counter and a stall-timeout error.
- Sits between the clock source and the CPU datapath and control units.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/phase_sequencer_if.sv | 26 ++
 rtl/stall_timer.sv | 37 +++
 rtl/phase_sequencer.sv | 107 ++++++++++
 tb/tb_phase_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-cycle sequencer.
// Phase vectors are [0:3] with bit 0 = fetch, so the literals read left to right.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, ERROR} seq_state_t;

  localparam int NUM_PHASES = 4;

  typedef logic [0:NUM_PHASES-1] phase_t;

  localparam phase_t PH_NONE   = 4'b0000;
  localparam phase_t PH_FETCH  = 4'b1000;
  localparam phase_t PH_DECODE = 4'b0100;
  localparam phase_t PH_EXEC   = 4'b0010;
  localparam phase_t PH_WB     = 4'b0001;

  function automatic logic is_mem_phase(input phase_t p);
    return (p == PH_FETCH) || (p == PH_EXEC);
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_FETCH:  n = PH_DECODE;
      PH_DECODE: n = PH_EXEC;
      PH_EXEC:   n = PH_WB;
      default:   n = PH_FETCH;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control and status bundle between the sequencer and the CPU datapath/control.
interface phase_sequencer_if import cpu_pkg::*; #(
  parameter int CNT_W = 16
) ();

  logic             run;
  logic             halt_req;
  logic             mem_ready;
  phase_t           phase;
  logic             mem_req;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             halted;
  logic             timeout_err;

  modport master (
    output run, halt_req, mem_ready,
    input  phase, mem_req, instr_done, instr_count, halted, timeout_err
  );

  modport slave (
    input  run, halt_req, mem_ready,
    output phase, mem_req, instr_done, instr_count, halted, timeout_err
  );

endinterface

// File: rtl/stall_timer.sv
// Counts consecutive stalled cycles of a memory phase; expired means the
// next stall would be number TIMEOUT.
module stall_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase fetch/decode/execute/writeback sequencer with memory stalls,
// boundary halting, retired-instruction counter and sticky stall timeout.
module phase_sequencer import cpu_pkg::*; #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  phase_sequencer_if.slave   bus
);

  seq_state_t       state_reg, state_next;
  phase_t           phase_reg, phase_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic stall_inc;
  logic stall_expired;

  stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!stall_inc),
    .inc     (stall_inc),
    .expired (stall_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      phase_reg <= PH_NONE;
      done_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    done_next  = 1'b0;
    count_next = count_reg;
    stall_inc  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.run && !bus.halt_req) begin
          state_next = RUN;
          phase_next = PH_FETCH;
        end
      end
      RUN: begin
        if (is_mem_phase(phase_reg) && !bus.mem_ready) begin
          if (stall_expired) begin
            state_next = ERROR;
            phase_next = PH_NONE;
          end else begin
            stall_inc = 1'b1;
          end
        end else if (phase_reg == PH_WB) begin
          // Instruction boundary: the only place run/halt_req are honoured.
          done_next  = 1'b1;
          count_next = count_reg + 1'b1;
          if (bus.halt_req) begin
            state_next = HALTED;
            phase_next = PH_NONE;
          end else if (!bus.run) begin
            state_next = IDLE;
            phase_next = PH_NONE;
          end else begin
            phase_next = PH_FETCH;
          end
        end else begin
          phase_next = next_phase(phase_reg);
        end
      end
      HALTED: begin
        if (!bus.halt_req) begin
          if (bus.run) begin
            state_next = RUN;
            phase_next = PH_FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      ERROR: begin
        phase_next = PH_NONE;
      end
      default: begin
        state_next = IDLE;
        phase_next = PH_NONE;
      end
    endcase
  end

  assign bus.phase       = phase_reg;
  assign bus.mem_req     = (state_reg == RUN) && is_mem_phase(phase_reg);
  assign bus.instr_done  = done_reg;
  assign bus.instr_count = count_reg;
  assign bus.halted      = (state_reg == HALTED);
  assign bus.timeout_err = (state_reg == ERROR);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed vector table plus hand-written corner sequences for phase_sequencer.
module tb_phase_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(16)) bus ();
  phase_sequencer_if #(.CNT_W(2))  bus2 ();

  phase_sequencer #(.CNT_W(16), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  phase_sequencer #(.CNT_W(2), .TIMEOUT(1)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int onehot_bad = 0;

  always @(negedge clk) begin
    assert ($onehot0(bus.phase) && $onehot0(bus2.phase))
    else onehot_bad++;
  end

  // expected = {phase, mem_req, instr_done, halted, timeout_err, instr_count}
  typedef struct packed {
    logic        run;
    logic        halt;
    logic        mr;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [0:42];

  function automatic vec_t mk(input logic [2:0] rhm, input logic [3:0] ph,
                              input logic [3:0] flags, input logic [15:0] cnt);
    vec_t v;
    v.run  = rhm[2];
    v.halt = rhm[1];
    v.mr   = rhm[0];
    v.exp  = {ph, flags, cnt};
    return v;
  endfunction

  function automatic logic [23:0] obs();
    return {bus.phase, bus.mem_req, bus.instr_done, bus.halted, bus.timeout_err, bus.instr_count};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flags = {mem_req, instr_done, halted, timeout_err}
    vecs[0]  = mk(3'b101, PH_FETCH,  4'b1000, 16'd0);
    vecs[1]  = mk(3'b101, PH_DECODE, 4'b0000, 16'd0);
    vecs[2]  = mk(3'b101, PH_EXEC,   4'b1000, 16'd0);
    vecs[3]  = mk(3'b101, PH_WB,     4'b0000, 16'd0);
    vecs[4]  = mk(3'b101, PH_FETCH,  4'b1100, 16'd1);
    vecs[5]  = mk(3'b101, PH_DECODE, 4'b0000, 16'd1);
    vecs[6]  = mk(3'b101, PH_EXEC,   4'b1000, 16'd1);
    vecs[7]  = mk(3'b101, PH_WB,     4'b0000, 16'd1);
    vecs[8]  = mk(3'b101, PH_FETCH,  4'b1100, 16'd2);
    vecs[9]  = mk(3'b101, PH_DECODE, 4'b0000, 16'd2);
    vecs[10] = mk(3'b101, PH_EXEC,   4'b1000, 16'd2);
    vecs[11] = mk(3'b101, PH_WB,     4'b0000, 16'd2);
    vecs[12] = mk(3'b101, PH_FETCH,  4'b1100, 16'd3);
    // stall in execute for three edges
    vecs[13] = mk(3'b101, PH_DECODE, 4'b0000, 16'd3);
    vecs[14] = mk(3'b101, PH_EXEC,   4'b1000, 16'd3);
    vecs[15] = mk(3'b100, PH_EXEC,   4'b1000, 16'd3);
    vecs[16] = mk(3'b100, PH_EXEC,   4'b1000, 16'd3);
    vecs[17] = mk(3'b100, PH_EXEC,   4'b1000, 16'd3);
    vecs[18] = mk(3'b101, PH_WB,     4'b0000, 16'd3);
    vecs[19] = mk(3'b101, PH_FETCH,  4'b1100, 16'd4);
    // halt requested mid-instruction
    vecs[20] = mk(3'b101, PH_DECODE, 4'b0000, 16'd4);
    vecs[21] = mk(3'b111, PH_EXEC,   4'b1000, 16'd4);
    vecs[22] = mk(3'b111, PH_WB,     4'b0000, 16'd4);
    vecs[23] = mk(3'b111, PH_NONE,   4'b0110, 16'd5);
    vecs[24] = mk(3'b111, PH_NONE,   4'b0010, 16'd5);
    vecs[25] = mk(3'b101, PH_FETCH,  4'b1000, 16'd5);
    // run dropped mid-instruction
    vecs[26] = mk(3'b001, PH_DECODE, 4'b0000, 16'd5);
    vecs[27] = mk(3'b001, PH_EXEC,   4'b1000, 16'd5);
    vecs[28] = mk(3'b001, PH_WB,     4'b0000, 16'd5);
    vecs[29] = mk(3'b001, PH_NONE,   4'b0100, 16'd6);
    vecs[30] = mk(3'b001, PH_NONE,   4'b0000, 16'd6);
    vecs[31] = mk(3'b111, PH_NONE,   4'b0000, 16'd6);
    // run=0 and halt_req=1 together at the boundary
    vecs[32] = mk(3'b101, PH_FETCH,  4'b1000, 16'd6);
    vecs[33] = mk(3'b101, PH_DECODE, 4'b0000, 16'd6);
    vecs[34] = mk(3'b101, PH_EXEC,   4'b1000, 16'd6);
    vecs[35] = mk(3'b011, PH_WB,     4'b0000, 16'd6);
    vecs[36] = mk(3'b011, PH_NONE,   4'b0110, 16'd7);
    vecs[37] = mk(3'b001, PH_NONE,   4'b0000, 16'd7);
    // mem_ready ignored outside memory phases
    vecs[38] = mk(3'b100, PH_FETCH,  4'b1000, 16'd7);
    vecs[39] = mk(3'b101, PH_DECODE, 4'b0000, 16'd7);
    vecs[40] = mk(3'b100, PH_EXEC,   4'b1000, 16'd7);
    vecs[41] = mk(3'b101, PH_WB,     4'b0000, 16'd7);
    vecs[42] = mk(3'b100, PH_FETCH,  4'b1100, 16'd8);

    bus.run = 1'b0;  bus.halt_req = 1'b0;  bus.mem_ready = 1'b0;
    bus2.run = 1'b0; bus2.halt_req = 1'b0; bus2.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(obs()), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'(obs()), 32'd0);

    // narrow instance: counter wrap at CNT_W=2 and TIMEOUT=1
    bus2.run = 1'b1;
    bus2.mem_ready = 1'b1;
    repeat (13) tick();
    check("wrap_cnt3", 32'(bus2.instr_count), 32'd3);
    repeat (4) tick();
    check("wrap_cnt0", 32'({bus2.instr_done, bus2.instr_count}), 32'({1'b1, 2'd0}));
    bus2.mem_ready = 1'b0;
    tick();
    check("timeout1_err", 32'({bus2.phase, bus2.timeout_err}), 32'({4'b0000, 1'b1}));
    bus2.run = 1'b0;

    for (int i = 0; i <= 42; i++) begin
      bus.run = vecs[i].run;
      bus.halt_req = vecs[i].halt;
      bus.mem_ready = vecs[i].mr;
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // fetch stall: 14 tolerated edges, the 15th lands in ERROR
    bus.run = 1'b1;
    bus.halt_req = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), 32'({bus.phase, bus.mem_req, bus.timeout_err}),
            32'({PH_FETCH, 1'b1, 1'b0}));
    end
    tick();
    check("timeout_enter", 32'({bus.phase, bus.mem_req, bus.timeout_err, bus.instr_count}),
          32'({PH_NONE, 1'b0, 1'b1, 16'd8}));
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    check("timeout_sticky", 32'({bus.phase, bus.timeout_err}), 32'({PH_NONE, 1'b1}));

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_clears_err", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset in the middle of an execute stall
    bus.run = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (5) tick();
    check("pre_reset_cnt", 32'({bus.phase, bus.instr_done, bus.instr_count}),
          32'({PH_FETCH, 1'b1, 16'd1}));
    repeat (2) tick();
    bus.mem_ready = 1'b0;
    tick();
    check("mid_stall", 32'({bus.phase, bus.mem_req, bus.instr_count}), 32'({PH_EXEC, 1'b1, 16'd1}));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'd0);
    bus.run = 1'b0;
    tick();
    check("reset_held", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", 32'(obs()), 32'd0);

    check("phase_onehot0", 32'(onehot_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
